nv_scan_chain_tx: RTL and testbench
===================================

# nv_scan_chain_tx

Parallel-to-serial chain transmitter for the NVDLA scan/config chain. It accepts a parallel word over a valid/ready load port and shifts it out LSB-first, one bit per accepted cycle, into a chain of scan-capable capture flops. It sits between the register/config front end and the chain head. It drives the serial data, shift-enable and last-bit markers, and honours a downstream stall.

## Interface
- DW, 32, width of the parallel word (max bits per frame)
- CNTW, 6, width of the length and counter fields; must satisfy 2^CNTW > DW

Ports:
- nvdla_core_clk  in  1  single clock; all state changes on its rising edge
- nvdla_core_rst  in  1  reset, synchronous and active-high
- load_pvld  in  1  load word valid
- load_prdy  out  1  load word ready
- load_pd  in  DW  parallel word to shift
- load_len  in  CNTW  number of bits to shift; 0 means DW, values > DW clamp to DW
- chain_rdy  in  1  downstream accepts the current bit this cycle
- chain_se  out  1  shift enable; the bit on chain_so is valid
- chain_so  out  1  serial data out
- chain_last  out  1  current bit is the final bit of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final bit is accepted

## Operation
- State machine has two states:
  - IDLE: load_prdy=1.
  - SHIFT: shifting a frame.
- Load handshake:
  - A word is accepted on an edge where load_pvld & load_prdy.
  - On acceptance, load_pd is captured into the shift register sh and the effective length into the counter rem = eff_len.
  - The state moves to SHIFT.
- In SHIFT, the bit-level outputs are:
  - chain_se=1
  - chain_so=sh[0]
  - chain_last=(rem==1)
  - busy=1
- Bit acceptance:
  - A bit is accepted on an edge where chain_se & chain_rdy.
  - On acceptance, sh shifts right with zero fill and rem decrements.
  - If chain_rdy=0, sh, rem and all outputs hold unchanged.
- When the last bit is accepted (chain_last & chain_rdy):
  - load_prdy=1 combinationally in that same cycle, so back-to-back frames run with no bubble.
  - If a new word is accepted on that edge, stay in SHIFT with the new sh and rem.
  - Otherwise go to IDLE.
- Effective length is 1..DW:
  - load_len==0 gives DW.
  - load_len>DW gives DW.
- done is registered. It is 1 in the cycle after the last-bit acceptance edge, and 0 otherwise.
- load_prdy=0 in SHIFT, except in the last-bit-accepted cycle described above.
- load_pd is ignored unless the handshake completes.

## Timing
- Reset is sampled at the rising edge.
  - After any edge with nvdla_core_rst=1: state=IDLE, sh=0, rem=0.
  - Output values after reset: chain_se=0, chain_so=0, chain_last=0, busy=0, done=0, load_prdy=1.
- Reset during SHIFT aborts the frame:
  - chain_se drops on the next cycle.
  - No done pulse.
  - No partial word is retained.
- Reset has priority over simultaneous load or bit handshakes. Nothing is accepted on a reset edge.
- Latency:
  - The first bit appears on chain_so in the cycle after the load edge.
  - With chain_rdy held at 1, an N-bit frame occupies exactly N cycles.
  - done asserts in cycle N+1 after the load edge.
- Throughput: one bit per cycle. Back-to-back frames have zero idle cycles between them.
- chain_se, chain_so, chain_last and busy are functions of registered state only.
- load_prdy depends combinationally on state, rem and chain_rdy.

## Test plan
- Reset then single frame:
  - Stimulus: after reset, load_pd=32'h0000_00A5, load_len=8, chain_rdy=1.
  - Required: chain_so sequence 1,0,1,0,0,1,0,1 over 8 cycles.
  - Required: chain_last only on cycle 8, done on cycle 9.
  - Required: busy=0 and load_prdy=1 afterwards.
- Stall:
  - Stimulus: same frame, with chain_rdy=0 for 3 cycles at bit 4.
  - Required: chain_so, chain_se and chain_last hold for 3 cycles.
  - Required: the frame completes in 11 cycles and done follows 1 cycle after the final acceptance.
- Back-to-back:
  - Stimulus: load_pvld held high with words 4'hF (len 4) then 4'h0 (len 4).
  - Required: load_prdy pulses on the last bit of the first frame.
  - Required: chain_so reads 1,1,1,1,0,0,0,0 with chain_se continuously high for 8 cycles.
  - Required: two done pulses, the first coinciding with the second frame's first bit.
- Length edge cases:
  - Stimulus: load_len=0, then load_len=40, each with load_pd=32'h8000_0001.
  - Required: each frame shifts 32 bits, with first bit 1, last bit 1 and chain_last on bit 32.
  - Stimulus: load_len=1.
  - Required: chain_last asserts together with the first bit.
- Reset mid-frame:
  - Stimulus: assert nvdla_core_rst for 1 cycle at bit 5 of a 16-bit frame.
  - Required: chain_se=0 from the next cycle, no done, load_prdy=1.
  - Required: a new frame loaded afterwards shifts correctly from bit 0.
- Ignored load:
  - Stimulus: load_pvld=1 mid-frame with a different load_pd.
  - Required: no acceptance and no corruption of the current frame's bits.

Source files
------------

// File: rtl/nv_scan_chain_tx_if.sv
// Load and chain-side signal bundle for nv_scan_chain_tx.
// slave = the transmitter, master = the config front end / chain model driving it.
interface nv_scan_chain_tx_if #(
  parameter int DW   = 32,
  parameter int CNTW = 6
);
  logic            load_pvld;
  logic            load_prdy;
  logic [DW-1:0]   load_pd;
  logic [CNTW-1:0] load_len;
  logic            chain_rdy;
  logic            chain_se;
  logic            chain_so;
  logic            chain_last;
  logic            busy;
  logic            done;

  modport slave (
    input  load_pvld, load_pd, load_len, chain_rdy,
    output load_prdy, chain_se, chain_so, chain_last, busy, done
  );

  modport master (
    output load_pvld, load_pd, load_len, chain_rdy,
    input  load_prdy, chain_se, chain_so, chain_last, busy, done
  );
endinterface

// File: rtl/nv_scan_chain_tx.sv
// Parallel-to-serial scan/config chain transmitter: loads a word, shifts it out
// LSB-first one bit per accepted cycle, with downstream stall and zero-bubble reload.
//
//   state    | meaning
//   ST_IDLE  | no frame; load port ready
//   ST_SHIFT | frame in progress; chain_so carries r_sh[0]
module nv_scan_chain_tx #(
  parameter int DW   = 32,
  parameter int CNTW = 6
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  nv_scan_chain_tx_if.slave      io
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  localparam logic [CNTW-1:0] LP_DW  = CNTW'(DW);
  localparam logic [CNTW-1:0] LP_ONE = CNTW'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [DW-1:0]   r_sh;
  logic [CNTW-1:0] r_rem;
  logic            r_done;

  logic            w_shift;
  logic            w_bit_acc;
  logic            w_last_acc;
  logic            w_load_prdy;
  logic            w_load_acc;
  logic [CNTW-1:0] w_eff_len;

  assign w_shift    = (r_state == ST_SHIFT);
  assign w_bit_acc  = w_shift && io.chain_rdy;
  assign w_last_acc = w_bit_acc && (r_rem == LP_ONE);

  // Zero and oversize lengths both mean a full-width frame.
  assign w_eff_len = ((io.load_len == '0) || (io.load_len > LP_DW)) ? LP_DW : io.load_len;

  always_comb begin
    w_next_state = r_state;
    w_load_prdy  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load_prdy = 1'b1;
        if (io.load_pvld) w_next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Opening the load port on the final accepted bit keeps frames back-to-back.
        w_load_prdy = w_last_acc;
        if (w_last_acc && !io.load_pvld) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_load_acc = io.load_pvld && w_load_prdy;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state <= ST_IDLE;
      r_sh    <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_last_acc;
      if (w_load_acc) begin
        r_sh  <= io.load_pd;
        r_rem <= w_eff_len;
      end else if (w_bit_acc) begin
        r_sh  <= {1'b0, r_sh[DW-1:1]};
        r_rem <= r_rem - LP_ONE;
      end
    end
  end

  // Short frames leave unshifted bits in r_sh, so gate the data with the state.
  assign io.chain_se   = w_shift;
  assign io.chain_so   = w_shift && r_sh[0];
  assign io.chain_last = w_shift && (r_rem == LP_ONE);
  assign io.busy       = w_shift;
  assign io.done       = r_done;
  assign io.load_prdy  = w_load_prdy;

endmodule

// File: tb/tb_nv_scan_chain_tx.sv
// Directed bench for nv_scan_chain_tx: table of single frames plus hand-written
// stall, back-to-back, reset-abort and ignored-load sequences.
module tb_nv_scan_chain_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  nv_scan_chain_tx_if #(.DW(32), .CNTW(6)) bus ();

  nv_scan_chain_tx #(.DW(32), .CNTW(6)) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .io             (bus)
  );

  typedef struct {
    logic [31:0] pd;
    logic [5:0]  len;
    int          nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " se"},   32'(bus.chain_se),   0);
    chk({nm, " so"},   32'(bus.chain_so),   0);
    chk({nm, " last"}, 32'(bus.chain_last), 0);
    chk({nm, " busy"}, 32'(bus.busy),       0);
    chk({nm, " prdy"}, 32'(bus.load_prdy),  1);
  endtask

  // Loads one frame from idle with chain_rdy=1 and checks every bit plus done.
  task automatic run_frame(input logic [31:0] pd, input logic [5:0] len, input int nbits);
    bus.chain_rdy = 1'b1;
    bus.load_pvld = 1'b1;
    bus.load_pd   = pd;
    bus.load_len  = len;
    @(negedge clk);
    chk("load prdy idle", 32'(bus.load_prdy), 1);
    tick();
    bus.load_pvld = 1'b0;
    bus.load_pd   = 32'hFFFF_FFFF;
    bus.load_len  = 6'd3;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      chk("frame se",   32'(bus.chain_se),   1);
      chk("frame so",   32'(bus.chain_so),   32'(pd[i]));
      chk("frame last", 32'(bus.chain_last), 32'(i == nbits - 1));
      chk("frame prdy", 32'(bus.load_prdy),  32'(i == nbits - 1));
      chk("frame done", 32'(bus.done),       0);
      tick();
    end
    @(negedge clk);
    chk("frame done pulse", 32'(bus.done), 1);
    chk_idle("frame end");
    tick();
    @(negedge clk);
    chk("frame done clear", 32'(bus.done), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [8:0] e_so, e_se, e_last, e_prdy, e_done;
    int bi, cyc, stalls;

    vecs[0] = '{32'h0000_00A5, 6'd8,  8};
    vecs[1] = '{32'h8000_0001, 6'd0,  32};
    vecs[2] = '{32'h8000_0001, 6'd40, 32};
    vecs[3] = '{32'hFFFF_FFFE, 6'd1,  1};
    vecs[4] = '{32'hDEAD_BEEF, 6'd31, 31};
    vecs[5] = '{32'h1234_5678, 6'd33, 32};

    rst = 1'b1;
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_00FF;
    bus.load_len  = 6'd8;
    bus.chain_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_idle("reset");
    chk("reset done", 32'(bus.done), 0);
    bus.load_pvld = 1'b0;
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk_idle("post reset");
    tick();

    for (int v = 0; v < 6; v++) run_frame(vecs[v].pd, vecs[v].len, vecs[v].nbits);

    // Stall: chain_rdy low for 3 cycles while the 4th bit is presented.
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_00A5;
    bus.load_len  = 6'd8;
    tick();
    bus.load_pvld = 1'b0;
    bi = 0; cyc = 0; stalls = 0;
    while (bi < 8 && cyc < 40) begin
      bus.chain_rdy = !(bi == 3 && stalls < 3);
      @(negedge clk);
      chk("stall se",   32'(bus.chain_se),   1);
      chk("stall so",   32'(bus.chain_so),   32'((32'h0000_00A5 >> bi) & 1));
      chk("stall last", 32'(bus.chain_last), 32'(bi == 7));
      chk("stall prdy", 32'(bus.load_prdy),  32'(bi == 7));
      tick();
      if (bus.chain_rdy) bi++;
      else stalls++;
      cyc++;
    end
    chk("stall cycles", 32'(cyc), 11);
    bus.chain_rdy = 1'b1;
    @(negedge clk);
    chk("stall done", 32'(bus.done), 1);
    chk_idle("stall end");
    tick();

    // Back-to-back: 4'hF then 4'h0, no bubble between frames.
    e_so   = 9'b000001111;
    e_se   = 9'b011111111;
    e_last = 9'b010001000;
    e_prdy = 9'b110001000;
    e_done = 9'b100010000;
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_000F;
    bus.load_len  = 6'd4;
    tick();
    bus.load_pd   = 32'h0000_0000;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) bus.load_pvld = 1'b0;
      @(negedge clk);
      chk("b2b se",   32'(bus.chain_se),   32'(e_se[c]));
      chk("b2b so",   32'(bus.chain_so),   32'(e_so[c]));
      chk("b2b last", 32'(bus.chain_last), 32'(e_last[c]));
      chk("b2b prdy", 32'(bus.load_prdy),  32'(e_prdy[c]));
      chk("b2b done", 32'(bus.done),       32'(e_done[c]));
      tick();
    end

    // Reset at bit 5 of a 16-bit frame, with a competing load on the reset edge.
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_BEEF;
    bus.load_len  = 6'd16;
    tick();
    bus.load_pvld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort so", 32'(bus.chain_so), 32'((32'h0000_BEEF >> i) & 1));
      tick();
    end
    rst = 1'b1;
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_FFFF;
    bus.load_len  = 6'd2;
    tick();
    rst = 1'b0;
    bus.load_pvld = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    chk("abort done", 32'(bus.done), 0);
    tick();
    @(negedge clk);
    chk("abort no done", 32'(bus.done), 0);
    chk("abort stays idle", 32'(bus.chain_se), 0);
    tick();
    run_frame(32'h0000_1234, 6'd16, 16);

    // Load attempt mid-frame must be ignored and must not disturb the bits.
    bus.load_pvld = 1'b1;
    bus.load_pd   = 32'h0000_00A5;
    bus.load_len  = 6'd8;
    tick();
    bus.load_pd   = 32'hFFFF_FFFF;
    bus.load_len  = 6'd3;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bus.load_pvld = 1'b0;
      @(negedge clk);
      chk("ignore so",   32'(bus.chain_so),   32'((32'h0000_00A5 >> i) & 1));
      chk("ignore last", 32'(bus.chain_last), 32'(i == 7));
      chk("ignore prdy", 32'(bus.load_prdy),  32'(i == 7));
      tick();
    end
    @(negedge clk);
    chk("ignore done", 32'(bus.done), 1);
    chk_idle("ignore end");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
